// File: rtl/execute_stage_m_if.sv
// execute_stage_m_if: decode-to-execute handshake, operands and EX/MEM result bundle.
// master = decode/downstream side, slave = execute stage.
interface execute_stage_m_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_BYP = 2
) ();
    localparam int unsigned SELW = $clog2(NUM_BYP + 1);

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         imm;
    logic [XLEN-1:0]         data_rs1;
    logic [XLEN-1:0]         data_rs2;
    logic                    ASel;
    logic                    BSel;
    logic                    BrUn;
    logic [3:0]              ALUSel;
    logic                    md_en;
    logic [2:0]              md_op;
    logic [SELW-1:0]         byp_sel_a;
    logic [SELW-1:0]         byp_sel_b;
    logic [NUM_BYP*XLEN-1:0] byp_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         ALURes;
    logic [XLEN-1:0]         store_data;
    logic                    BrEq;
    logic                    BrLT;
    logic                    illegal_op;
    logic                    busy;

    modport master (
        output flush, in_valid, pc, imm, data_rs1, data_rs2, ASel, BSel, BrUn, ALUSel,
               md_en, md_op, byp_sel_a, byp_sel_b, byp_data, out_ready,
        input  in_ready, out_valid, ALURes, store_data, BrEq, BrLT, illegal_op, busy
    );

    modport slave (
        input  flush, in_valid, pc, imm, data_rs1, data_rs2, ASel, BSel, BrUn, ALUSel,
               md_en, md_op, byp_sel_a, byp_sel_b, byp_data, out_ready,
        output in_ready, out_valid, ALURes, store_data, BrEq, BrLT, illegal_op, busy
    );
endinterface

// File: rtl/execute_stage_m.sv
// execute_stage_m: execute stage with EX/MEM output register, N-way forwarding and an
// iterative RV32M multiply/divide unit present only when EXEC_MDU_EN is defined.
module execute_stage_m #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_BYP = 2,
    parameter int unsigned SELW    = $clog2(NUM_BYP + 1)
) (
    input logic              clk,
    input logic              rst_n,
    execute_stage_m_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_res;
    logic            br_eq_c, br_lt_c;
    logic            out_free, accept;
    logic            out_valid_q, illegal_q, br_eq_q, br_lt_q;
    logic [XLEN-1:0] res_q, store_q;

    // Operand forwarding; out-of-range selects fall back to the register file.
    always_comb begin
        fwd_a = bus.data_rs1;
        fwd_b = bus.data_rs2;
        for (int unsigned k = 1; k <= NUM_BYP; k++) begin
            if (bus.byp_sel_a == SELW'(k)) fwd_a = bus.byp_data[(k-1)*XLEN +: XLEN];
            if (bus.byp_sel_b == SELW'(k)) fwd_b = bus.byp_data[(k-1)*XLEN +: XLEN];
        end
    end

    assign alu_a = bus.ASel ? bus.pc  : fwd_a;
    assign alu_b = bus.BSel ? bus.imm : fwd_b;

    always_comb begin
        alu_res = '0;
        case (bus.ALUSel)
            4'd0:    alu_res = alu_a + alu_b;
            4'd1:    alu_res = alu_a << alu_b[SHW-1:0];
            4'd2:    alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
            4'd4:    alu_res = alu_a ^ alu_b;
            4'd5:    alu_res = alu_a >> alu_b[SHW-1:0];
            4'd6:    alu_res = alu_a | alu_b;
            4'd7:    alu_res = alu_a & alu_b;
            4'd12:   alu_res = alu_a - alu_b;
            4'd13:   alu_res = XLEN'($signed(alu_a) >>> alu_b[SHW-1:0]);
            4'd14:   alu_res = XLEN'(alu_a < alu_b);
            4'd15:   alu_res = alu_b;
            default: alu_res = '0;
        endcase
    end

    assign br_eq_c = (fwd_a == fwd_b);
    assign br_lt_c = bus.BrUn ? (fwd_a < fwd_b) : ($signed(fwd_a) < $signed(fwd_b));

    assign out_free = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef EXEC_MDU_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam int unsigned CNTW = $clog2(XLEN + 1);

    state_t            state, state_nxt;
    logic [CNTW-1:0]   cnt;
    logic [2*XLEN-1:0] acc, mul_next, div_next, prod;
    logic [XLEN-1:0]   ra, rb, mag_b, quo, rem, md_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2:0]        op_q;
    logic              idle_c, iter_c, done_c, last_iter_c, sa, sb;

    function automatic logic a_signed(input logic [2:0] op);
        return op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return op inside {3'd0, 3'd1, 3'd4, 3'd6};
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic s);
        return (s && v[XLEN-1]) ? -v : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept && bus.md_en) state_nxt = bus.md_op[2] ? DIV : MUL;
            MUL, DIV: if (last_iter_c) state_nxt = DONE;
            DONE:     if (out_free) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_comb begin
        idle_c = 1'b0;
        iter_c = 1'b0;
        done_c = 1'b0;
        case (state)
            IDLE:     idle_c = 1'b1;
            MUL, DIV: iter_c = 1'b1;
            DONE:     done_c = 1'b1;
            default:  idle_c = 1'b0;
        endcase
    end

    assign last_iter_c = (cnt == CNTW'(XLEN - 1));

    // Multiplier sits in acc low half; each step adds the multiplicand into the high half.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}.
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            acc   <= '0;
            ra    <= '0;
            rb    <= '0;
            mag_b <= '0;
            op_q  <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (accept && bus.md_en) begin
            cnt  <= '0;
            ra   <= fwd_a;
            rb   <= fwd_b;
            op_q <= bus.md_op;
            if (bus.md_op[2]) begin
                acc   <= {XLEN'(0), mag(fwd_a, a_signed(bus.md_op))};
                mag_b <= mag(fwd_b, b_signed(bus.md_op));
            end else begin
                acc   <= {XLEN'(0), mag(fwd_b, b_signed(bus.md_op))};
                mag_b <= mag(fwd_a, a_signed(bus.md_op));
            end
        end else if (iter_c) begin
            cnt <= last_iter_c ? '0 : cnt + CNTW'(1);
            acc <= (state == MUL) ? mul_next : div_next;
        end
    end

    // Sign correction and RISC-V divide corner cases.
    always_comb begin
        sa   = a_signed(op_q) && ra[XLEN-1];
        sb   = b_signed(op_q) && rb[XLEN-1];
        prod = (sa ^ sb) ? -acc : acc;
        quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:             md_res = prod[XLEN-1:0];
            3'd1, 3'd2, 3'd3: md_res = prod[2*XLEN-1:XLEN];
            3'd4, 3'd5:       md_res = quo;
            default:          md_res = rem;
        endcase
        if (op_q[2] && (rb == '0)) begin
            md_res = op_q[1] ? ra : '1;
        end else if (op_q[2] && !op_q[0] && (ra == {1'b1, {(XLEN-1){1'b0}}}) && (rb == '1)) begin
            md_res = op_q[1] ? '0 : ra;
        end
    end

    assign bus.in_ready = idle_c && out_free;
    assign bus.busy     = !idle_c;
`else
    logic unused_md_op;

    assign unused_md_op = ^bus.md_op;
    assign bus.in_ready = out_free;
    assign bus.busy     = 1'b0;
`endif

    // EX/MEM output register; flush wins over any load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            res_q       <= '0;
            store_q     <= '0;
            br_eq_q     <= 1'b0;
            br_lt_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept && !bus.md_en) begin
            out_valid_q <= 1'b1;
            res_q       <= alu_res;
            store_q     <= fwd_b;
            br_eq_q     <= br_eq_c;
            br_lt_q     <= br_lt_c;
            illegal_q   <= 1'b0;
`ifdef EXEC_MDU_EN
        end else if (done_c && out_free) begin
            out_valid_q <= 1'b1;
            res_q       <= md_res;
            store_q     <= rb;
            br_eq_q     <= 1'b0;
            br_lt_q     <= 1'b0;
            illegal_q   <= 1'b0;
`else
        end else if (accept) begin
            out_valid_q <= 1'b1;
            res_q       <= '0;
            store_q     <= fwd_b;
            br_eq_q     <= 1'b0;
            br_lt_q     <= 1'b0;
            illegal_q   <= 1'b1;
`endif
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.ALURes     = res_q;
    assign bus.store_data = store_q;
    assign bus.BrEq       = br_eq_q;
    assign bus.BrLT       = br_lt_q;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_execute_stage_m.sv
// tb_execute_stage_m: directed self-checking bench for execute_stage_m (XLEN=32, NUM_BYP=2).
module tb_execute_stage_m;
    localparam logic [3:0] OP_ADD = 4'd0,  OP_SLL = 4'd1,  OP_SLT = 4'd2,  OP_XOR = 4'd4;
    localparam logic [3:0] OP_SRL = 4'd5,  OP_OR  = 4'd6,  OP_AND = 4'd7,  OP_SUB = 4'd12;
    localparam logic [3:0] OP_SRA = 4'd13, OP_SLTU = 4'd14, OP_BSEL = 4'd15;

    localparam int NV = 11;
    localparam logic [31:0] VA [NV] = '{32'h7FFFFFFF, 32'h5, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h80000000, 32'h80000000, 32'hDEAD};
    localparam logic [31:0] VB [NV] = '{32'h1, 32'h7, 32'h24, 32'h1, 32'h1,
        32'hFF00FF00, 32'h0F000000, 32'hFF00FF00, 32'h4, 32'h4, 32'h1234};
    localparam logic [3:0]  VS [NV] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_OR, OP_AND, OP_SRL, OP_SRA, OP_BSEL};
    localparam logic [31:0] VE [NV] = '{32'h80000000, 32'hFFFFFFFE, 32'h30, 32'h1, 32'h0,
        32'h0FF00FF0, 32'hFFF0F0F0, 32'hF000F000, 32'h08000000, 32'hF8000000, 32'h1234};

    localparam int NM = 13;
    localparam logic [2:0]  MO [NM] = '{3'd1, 3'd3, 3'd0, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
        3'd4, 3'd6, 3'd5, 3'd7, 3'd4};
    localparam logic [31:0] MA [NM] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE,
        32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000, 32'h80000000, 32'd7, 32'd7,
        32'hFFFFFFFB};
    localparam logic [31:0] MB [NM] = '{32'h3, 32'h3, 32'h3, 32'h3, 32'h2, 32'h2, 32'd7, 32'd7,
        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    localparam logic [31:0] ME [NM] = '{32'hFFFFFFFF, 32'h2, 32'hFFFFFFFA, 32'hFFFFFFFF,
        32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'd7,
        32'hFFFFFFFF};

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    execute_stage_m_if #(.XLEN(32), .NUM_BYP(2)) bus ();

    execute_stage_m #(.XLEN(32), .NUM_BYP(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.pc = '0; bus.imm = '0;
        bus.data_rs1 = '0; bus.data_rs2 = '0; bus.ASel = 1'b0; bus.BSel = 1'b0;
        bus.BrUn = 1'b0; bus.ALUSel = OP_ADD; bus.md_en = 1'b0; bus.md_op = 3'd0;
        bus.byp_sel_a = 2'd0; bus.byp_sel_b = 2'd0; bus.out_ready = 1'b1;
    endtask

    task automatic drive_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
        bus.in_valid = 1'b1; bus.md_en = 1'b0; bus.data_rs1 = a; bus.data_rs2 = b;
        bus.ALUSel = sel; bus.ASel = 1'b0; bus.BSel = 1'b0;
        bus.byp_sel_a = 2'd0; bus.byp_sel_b = 2'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.byp_data = '0;
        #12;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.ALURes !== 32'h0) begin n_err++; $display("FAIL reset_ALURes got=%h exp=0", bus.ALURes); end
        n_cmp++; if (bus.store_data !== 32'h0) begin n_err++; $display("FAIL reset_store_data got=%h exp=0", bus.store_data); end
        n_cmp++; if ({bus.BrEq, bus.BrLT, bus.illegal_op} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {bus.BrEq, bus.BrLT, bus.illegal_op}); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_forwarding();
        bus.byp_data = {32'h10, 32'h7};
        drive_alu(32'h100, 32'h5, OP_ADD);
        bus.byp_sel_a = 2'd2;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fwd_in_ready got=%b exp=1", bus.in_ready); end
        step();
        n_cmp++; if (bus.ALURes !== 32'h15 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL fwd_sel_a2 got=%h/%b exp=15/1", bus.ALURes, bus.out_valid); end
        n_cmp++; if (bus.store_data !== 32'h5) begin n_err++; $display("FAIL fwd_store_rf got=%h exp=5", bus.store_data); end
        bus.byp_sel_a = 2'd3;
        step();
        n_cmp++; if (bus.ALURes !== 32'h105) begin n_err++; $display("FAIL fwd_sel_a3 got=%h exp=105", bus.ALURes); end
        bus.byp_sel_a = 2'd1;
        step();
        n_cmp++; if (bus.ALURes !== 32'hC) begin n_err++; $display("FAIL fwd_sel_a1 got=%h exp=c", bus.ALURes); end
        bus.byp_sel_a = 2'd0; bus.byp_sel_b = 2'd1;
        step();
        n_cmp++; if (bus.ALURes !== 32'h107 || bus.store_data !== 32'h7) begin n_err++; $display("FAIL fwd_sel_b1 got=%h/%h exp=107/7", bus.ALURes, bus.store_data); end
        bus.byp_sel_b = 2'd2;
        step();
        n_cmp++; if (bus.ALURes !== 32'h110 || bus.store_data !== 32'h10) begin n_err++; $display("FAIL fwd_sel_b2 got=%h/%h exp=110/10", bus.ALURes, bus.store_data); end
        clear_inputs();
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL fwd_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_alu_ops();
        for (int i = 0; i < NV; i++) begin
            drive_alu(VA[i], VB[i], VS[i]);
            step();
            n_cmp++;
            if (bus.ALURes !== VE[i] || bus.out_valid !== 1'b1 || bus.illegal_op !== 1'b0) begin
                n_err++;
                $display("FAIL alu_vec%0d got=%h/%b/%b exp=%h/1/0", i, bus.ALURes, bus.out_valid, bus.illegal_op, VE[i]);
            end
        end
        drive_alu(32'h5, 32'h6, OP_ADD);
        bus.pc = 32'h1000; bus.imm = 32'h24; bus.ASel = 1'b1; bus.BSel = 1'b1;
        step();
        n_cmp++; if (bus.ALURes !== 32'h1024) begin n_err++; $display("FAIL alu_pc_imm got=%h exp=1024", bus.ALURes); end
        bus.ASel = 1'b0;
        step();
        n_cmp++; if (bus.ALURes !== 32'h29 || bus.store_data !== 32'h6) begin n_err++; $display("FAIL alu_rs1_imm got=%h/%h exp=29/6", bus.ALURes, bus.store_data); end
        clear_inputs();
        step();
    endtask

    task automatic test_branch_flags();
        drive_alu(32'hFFFFFFFF, 32'h1, OP_ADD);
        bus.BrUn = 1'b0;
        step();
        n_cmp++; if ({bus.BrEq, bus.BrLT} !== 2'b01) begin n_err++; $display("FAIL br_signed got=%b exp=01", {bus.BrEq, bus.BrLT}); end
        bus.BrUn = 1'b1;
        step();
        n_cmp++; if ({bus.BrEq, bus.BrLT} !== 2'b00) begin n_err++; $display("FAIL br_unsigned got=%b exp=00", {bus.BrEq, bus.BrLT}); end
        drive_alu(32'h55, 32'h55, OP_ADD);
        step();
        n_cmp++; if ({bus.BrEq, bus.BrLT} !== 2'b10) begin n_err++; $display("FAIL br_equal got=%b exp=10", {bus.BrEq, bus.BrLT}); end
        drive_alu(32'h7, 32'h99, OP_ADD);
        bus.byp_sel_b = 2'd1;
        step();
        n_cmp++; if (bus.BrEq !== 1'b1 || bus.store_data !== 32'h7) begin n_err++; $display("FAIL br_forwarded got=%b/%h exp=1/7", bus.BrEq, bus.store_data); end
        clear_inputs();
        step();
    endtask

    task automatic test_back_pressure();
        drive_alu(32'h11, 32'h22, OP_ADD);
        bus.out_ready = 1'b0;
        step();
        drive_alu(32'h1, 32'h1, OP_ADD);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, bus.in_ready); end
            step();
            n_cmp++; if (bus.ALURes !== 32'h33 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d got=%h/%b exp=33/1", i, bus.ALURes, bus.out_valid); end
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b exp=1", bus.in_ready); end
        step();
        n_cmp++; if (bus.ALURes !== 32'h2 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next got=%h/%b exp=2/1", bus.ALURes, bus.out_valid); end
        clear_inputs();
        step();
    endtask

    task automatic test_flush();
        drive_alu(32'h3, 32'h4, OP_ADD);
        bus.out_ready = 1'b0;
        step();
        bus.flush = 1'b1;
        drive_alu(32'h8, 32'h8, OP_ADD);
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_kill got=%b exp=0", bus.out_valid); end
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_accept got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_reset_pending();
        drive_alu(32'h1, 32'h2, OP_ADD);
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rstp_pending got=%b exp=1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.ALURes !== 32'h0) begin n_err++; $display("FAIL rstp_async got=%b/%h exp=0/0", bus.out_valid, bus.ALURes); end
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive_alu(32'h5, 32'h6, OP_ADD);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rstp_ready got=%b exp=1", bus.in_ready); end
        step();
        n_cmp++; if (bus.ALURes !== 32'hB || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rstp_next got=%h/%b exp=b/1", bus.ALURes, bus.out_valid); end
        clear_inputs();
        step();
    endtask

`ifdef EXEC_MDU_EN
    task automatic issue_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat, output bit saw_ready);
        drive_alu(a, b, OP_ADD);
        bus.md_en = 1'b1; bus.md_op = op; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.md_en = 1'b0;
        lat = 0;
        saw_ready = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.in_ready !== 1'b0) saw_ready = 1'b1;
            step();
            lat++;
        end
    endtask

    task automatic test_mdu_ops();
        int lat;
        bit saw;
        for (int i = 0; i < NM; i++) begin
            issue_md(MO[i], MA[i], MB[i], lat, saw);
            n_cmp++; if (bus.ALURes !== ME[i]) begin n_err++; $display("FAIL md_vec%0d op%0d got=%h exp=%h", i, MO[i], bus.ALURes, ME[i]); end
            n_cmp++; if (lat != 33 || saw) begin n_err++; $display("FAIL md_lat%0d got=%0d/%b exp=33/0", i, lat, saw); end
            n_cmp++; if (bus.store_data !== MB[i] || {bus.BrEq, bus.BrLT, bus.illegal_op} !== 3'b000) begin n_err++; $display("FAIL md_side%0d got=%h/%b exp=%h/000", i, bus.store_data, {bus.BrEq, bus.BrLT, bus.illegal_op}, MB[i]); end
        end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL md_busy_end got=%b exp=0", bus.busy); end
        step();
    endtask

    task automatic test_reset_mid_mdu();
        drive_alu(32'd100, 32'd7, OP_ADD);
        bus.md_en = 1'b1; bus.md_op = 3'd4;
        step();
        bus.in_valid = 1'b0; bus.md_en = 1'b0;
        repeat (10) step();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rstm_busy got=%b exp=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstm_async got=%b/%b exp=0/0", bus.busy, bus.out_valid); end
        #2;
        rst_n = 1'b1;
        drive_alu(32'h20, 32'h3, OP_SUB);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rstm_ready got=%b exp=1", bus.in_ready); end
        step();
        n_cmp++; if (bus.ALURes !== 32'h1D || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rstm_next got=%h/%b exp=1d/1", bus.ALURes, bus.out_valid); end
        clear_inputs();
        step();
    endtask

    task automatic test_flush_mul();
        bit late;
        drive_alu(32'h6, 32'h7, OP_ADD);
        bus.md_en = 1'b1; bus.md_op = 3'd0;
        step();
        bus.in_valid = 1'b0; bus.md_en = 1'b0;
        repeat (5) step();
        bus.flush = 1'b1;
        drive_alu(32'h1, 32'h1, OP_ADD);
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL fm_kill got=%b/%b exp=0/0", bus.out_valid, bus.busy); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fm_ready got=%b exp=1", bus.in_ready); end
        late = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.out_valid !== 1'b0) late = 1'b1;
        end
        n_cmp++; if (late) begin n_err++; $display("FAIL fm_late_result got=1 exp=0"); end
    endtask
`else
    task automatic test_illegal_md();
        drive_alu(32'h5, 32'h6, OP_ADD);
        bus.md_en = 1'b1; bus.md_op = 3'd4;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL ill_ready got=%b/%b exp=1/0", bus.in_ready, bus.busy); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.ALURes !== 32'h0) begin n_err++; $display("FAIL ill_result got=%b/%h exp=1/0", bus.out_valid, bus.ALURes); end
        n_cmp++; if (bus.illegal_op !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL ill_flag got=%b/%b exp=1/0", bus.illegal_op, bus.busy); end
        drive_alu(32'h5, 32'h6, OP_ADD);
        step();
        n_cmp++; if (bus.illegal_op !== 1'b0 || bus.ALURes !== 32'hB) begin n_err++; $display("FAIL ill_clear got=%b/%h exp=0/b", bus.illegal_op, bus.ALURes); end
        clear_inputs();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_alu_ops();
        test_branch_flags();
        test_back_pressure();
        test_flush();
        test_reset_pending();
`ifdef EXEC_MDU_EN
        test_mdu_ops();
        test_reset_mid_mdu();
        test_flush_mul();
`else
        test_illegal_md();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/execute_stage_m.md
Name: execute_stage_m

Overview:
Parametrised execute stage with an integrated output (EX/MEM) register, N-way operand forwarding and an iterative RV32M multiply/divide unit.
- Single-cycle integer ops: computed by the existing alu and branch_comparator modules; registered in one cycle.
- M-extension ops: run a multi-cycle FSM that back-pressures decode via a valid/ready handshake.

Parameters:
XLEN, 32, datapath width; must be even and at least 8.
NUM_BYP, 2, number of forwarding sources in addition to the register file.
SELW, $clog2(NUM_BYP+1), forwarding-select width (derived; do not override).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of the in-flight op and the output register.
in_valid  in  1  decode presents an op.
in_ready  out  1  stage accepts the op this cycle.
pc, imm, data_rs1, data_rs2  in  XLEN each  operands from decode.
ASel, BSel, BrUn  in  1 each  A=pc, B=imm, unsigned compare.
ALUSel  in  4  existing alu op encoding.
md_en  in  1  op is RV32M.
md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
byp_sel_a, byp_sel_b  in  SELW each  forwarding select per operand.
byp_data  in  NUM_BYP*XLEN  forwarding sources; source k occupies bits [k*XLEN +: XLEN].
out_valid  out  1  output register holds a result.
out_ready  in  1  downstream consumes the result.
ALURes  out  XLEN  registered result.
store_data  out  XLEN  registered forwarded rs2 value.
BrEq, BrLT  out  1 each  registered compare flags.
illegal_op  out  1  registered; high when md_en is seen without MDU hardware.
busy  out  1  MDU FSM not IDLE.

Behaviour:
Reset (rst_n low, asynchronous):
- out_valid, ALURes, store_data, BrEq, BrLT and illegal_op go to 0.
- FSM goes to IDLE; the iteration counter goes to 0.

Forwarding:
- sel = 0 selects data_rs1/data_rs2.
- sel = k in 1..NUM_BYP selects byp_data source k-1.
- sel > NUM_BYP selects the register-file value.
- Forwarded values feed the comparator, the MDU and store_data.
- The ASel/BSel muxes then apply in front of the alu.

Handshake:
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
- Output register is held while out_valid && !out_ready.

Non-M op:
- On accept, the next edge loads ALURes, store_data and the flags, and sets out_valid=1.
- Latency is 1 cycle.
- Back-to-back accepts are allowed at 1/cycle.

M op (md_en):
- On accept, latch the forwarded operands and md_op, and go to MUL or DIV.
- MUL: shift-add on operand magnitudes into a 2*XLEN product, 1 bit/cycle, XLEN iterations. Then apply sign-correct negation using the signedness rules of MULH/MULHSU/MULHU.
- DIV: restoring division on magnitudes, 1 bit/cycle, XLEN iterations. The quotient sign is sa^sb; the remainder takes the dividend sign.
- After iteration XLEN, enter DONE. On the next edge (gated by output-register availability), load ALURes and set out_valid; FSM returns to IDLE.
- Minimum latency from accept edge to out_valid: XLEN+2 edges.
- For M ops, BrEq/BrLT are 0 and store_data is the forwarded rs2 value.
- MUL returns the low XLEN bits; MULH* return the high XLEN bits.

Division corner cases (checked in DONE; iteration still runs full length):
- Divisor 0: DIV/DIVU = all ones; REM/REMU = dividend.
- Signed overflow (dividend = -2^(XLEN-1), divisor = -1): DIV = dividend; REM = 0.

Flush:
- Has priority over accept and completion in the same cycle.
- Next edge: out_valid=0, FSM to IDLE, counter to 0.
- An op presented alongside flush is not accepted.

out_ready while out_valid=0 is ignored. busy is high in MUL, DIV and DONE.

Optional Feature:
EXEC_MDU_EN.
- Defined: MDU FSM and datapath present, as described above.
- Undefined: no MDU logic. An accepted md_en op completes in 1 cycle with ALURes=0 and illegal_op=1. busy is tied to 0.
- illegal_op is always 0 for non-M ops in both builds.

Test Plan:
Reset mid-MDU: assert rst_n low during DIV iteration 10 -> out_valid=0 and busy=0 immediately; the next op is accepted on the first cycle after release.

Forwarding: XLEN=32, NUM_BYP=2, byp_sel_a=2, source1=0x10, rs2=0x5, ALUSel=ADD -> ALURes=0x15 one cycle after accept. byp_sel_a=3 -> uses data_rs1.

MULH: rs1=0xFFFFFFFE, rs2=0x00000003 -> 0xFFFFFFFF. MULHU with the same operands -> 0x00000002. Each result appears 34 edges after accept; in_ready stays low meanwhile.

DIV corners: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. DIVU 7/0 -> 0xFFFFFFFF. REMU 7/0 -> 7.

Back-pressure: hold out_ready=0 with a result pending and keep in_valid=1 -> in_ready=0 and the result is held stable. Release out_ready -> next op is accepted that cycle.

Flush during MUL: flush at iteration 5 together with in_valid=1 -> no accept, out_valid stays 0, FSM IDLE. Without EXEC_MDU_EN: md_en op -> ALURes=0, illegal_op=1 after 1 cycle.
